// File: rtl/fifo_wr_arb.sv
// Four-requester round-robin write arbiter in front of a synchronous FIFO.
// A grant lasts one burst of up to MAX_BURST beats; FIFO writes are registered.
//
//   state | meaning
//   IDLE  | no owner; arbitrate among pending requests
//   BURST | owner streams beats until last, MAX_BURST, or withdrawal
module fifo_wr_arb #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] req_data,
  input  logic [3:0]         req_last,
  output logic [3:0]         gnt,
  input  logic               fifo_full,
  output logic               fifo_wr_en,
  output logic [WIDTH-1:0]   fifo_din,
  output logic [1:0]         owner,
  output logic               busy,
  output logic [15:0]        wr_count
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

  state_t             state_q;
  logic [1:0]         owner_q;
  logic [1:0]         last_owner_q;
  logic [3:0]         beat_cnt_q;
  logic [3:0]         beat_cnt_d;
  logic               fifo_wr_en_q;
  logic [WIDTH-1:0]   fifo_din_q;
  logic [15:0]        wr_count_q;
  logic [15:0]        wr_count_d;

  logic [1:0]         winner;
  logic [1:0]         cand;
  logic               found;
  logic [WIDTH-1:0]   owner_data;
  logic               acc;
  logic               burst_end;

  // Search starts one past the previous owner so every requester gets a turn.
  always_comb begin
    winner = last_owner_q;
    cand   = '0;
    found  = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_owner_q + 2'(i);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    owner_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (owner_q == 2'(i)) owner_data = req_data[i*WIDTH +: WIDTH];
    end
  end

  assign acc        = (state_q == BURST) && req[owner_q] && !fifo_full;
  assign burst_end  = req_last[owner_q] || (beat_cnt_q == LAST_BEAT);
  assign beat_cnt_d = beat_cnt_q + 4'd1;
  assign wr_count_d = wr_count_q + 16'd1;

  always_comb begin
    gnt = '0;
    if (acc) gnt[owner_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 2'd0;
      last_owner_q <= 2'd3;
      beat_cnt_q   <= '0;
      fifo_wr_en_q <= 1'b0;
      fifo_din_q   <= '0;
      wr_count_q   <= '0;
    end else begin
      fifo_wr_en_q <= acc;
      if (acc) begin
        fifo_din_q <= owner_data;
        wr_count_q <= wr_count_d;
      end

      case (state_q)
        IDLE: begin
          if (req != 4'b0000) begin
            owner_q    <= winner;
            beat_cnt_q <= '0;
            state_q    <= BURST;
          end
        end
        BURST: begin
          if (!req[owner_q]) begin
            state_q      <= IDLE;
            last_owner_q <= owner_q;
          end else if (acc) begin
            beat_cnt_q <= beat_cnt_d;
            if (burst_end) begin
              state_q      <= IDLE;
              last_owner_q <= owner_q;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_wr_en = fifo_wr_en_q;
  assign fifo_din   = fifo_din_q;
  assign owner      = owner_q;
  assign busy       = (state_q == BURST);
  assign wr_count   = wr_count_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Randomized and directed bench for fifo_wr_arb against a cycle-level reference
// model, plus MAX_BURST=1 and 16-bit write counter wrap instances.
module tb_fifo_wr_arb;
  localparam int W  = 8;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]     req, req_last, gnt;
  logic [4*W-1:0] req_data;
  logic           fifo_full, fifo_wr_en, busy;
  logic [W-1:0]   fifo_din;
  logic [1:0]     owner;
  logic [15:0]    wr_count;

  logic [3:0]     req16, last16, gnt16;
  logic [4*W-1:0] data16;
  logic           full16, wen16, busy16;
  logic [W-1:0]   din16;
  logic [1:0]     own16;
  logic [15:0]    cnt16;

  logic [3:0]     req1, last1, gnt1;
  logic [4*W-1:0] data1;
  logic           full1, wen1, busy1;
  logic [W-1:0]   din1;
  logic [1:0]     own1;
  logic [15:0]    cnt1;

  fifo_wr_arb #(.WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
    .gnt(gnt), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
    .owner(owner), .busy(busy), .wr_count(wr_count));

  fifo_wr_arb #(.WIDTH(W), .MAX_BURST(16)) dut16 (
    .clk(clk), .rst(rst), .req(req16), .req_data(data16), .req_last(last16),
    .gnt(gnt16), .fifo_full(full16), .fifo_wr_en(wen16), .fifo_din(din16),
    .owner(own16), .busy(busy16), .wr_count(cnt16));

  fifo_wr_arb #(.WIDTH(W), .MAX_BURST(1)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .req_data(data1), .req_last(last1),
    .gnt(gnt1), .fifo_full(full1), .fifo_wr_en(wen1), .fifo_din(din1),
    .owner(own1), .busy(busy1), .wr_count(cnt1));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: who owns the FIFO, how many beats they have sent.
  bit          m_busy;
  int          m_owner, m_last, m_beats;
  logic        m_wr_en;
  logic [W-1:0] m_din;
  logic [15:0] m_cnt;
  logic [W-1:0] writes[$];
  int          owners[$];
  logic        prev_busy;

  function automatic logic [4*W-1:0] rnd_data();
    return (4*W)'($urandom);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_last = 3; m_beats = 0;
    m_wr_en = 1'b0; m_din = '0; m_cnt = '0;
    writes.delete(); owners.delete(); prev_busy = 1'b0;
  endtask

  task automatic clear_inputs();
    req = '0; req_data = '0; req_last = '0; fifo_full = 1'b0;
    req16 = '0; data16 = '0; last16 = '0; full16 = 1'b0;
    req1 = '0; data1 = '0; last1 = '0; full1 = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // One clock of the main DUT: drive, check combinational view, step model, check registered view.
  task automatic cycle(input logic [3:0] r, input logic [4*W-1:0] d,
                       input logic [3:0] l, input logic f);
    logic [3:0] eg;
    bit acc, found;
    int c;
    req = r; req_data = d; req_last = l; fifo_full = f;
    #2;
    eg = '0; acc = 0;
    if (m_busy && r[m_owner] && !f) begin
      acc = 1;
      eg[m_owner] = 1'b1;
    end
    n_checks += 3;
    if (gnt !== eg) begin
      n_fail++; $display("FAIL gnt t=%0t got %b expected %b", $time, gnt, eg);
    end
    if (busy !== m_busy) begin
      n_fail++; $display("FAIL busy t=%0t got %b expected %b", $time, busy, m_busy);
    end
    if (owner !== 2'(m_owner)) begin
      n_fail++; $display("FAIL owner t=%0t got %0d expected %0d", $time, owner, m_owner);
    end
    if (busy === 1'b1 && prev_busy !== 1'b1) owners.push_back(int'(owner));
    prev_busy = busy;

    if (!m_busy) begin
      if (r != 4'b0000) begin
        found = 0;
        for (int k = 1; k <= 4; k++) begin
          c = (m_last + k) % 4;
          if (!found && r[c]) begin
            m_owner = c;
            found = 1;
          end
        end
        m_beats = 0;
        m_busy  = 1;
      end
    end else if (!r[m_owner]) begin
      m_busy = 0;
      m_last = m_owner;
    end else if (acc) begin
      m_beats++;
      if (l[m_owner] || m_beats == MB) begin
        m_busy = 0;
        m_last = m_owner;
      end
    end
    m_wr_en = acc;
    if (acc) begin
      m_din = d[m_owner*W +: W];
      m_cnt = m_cnt + 16'd1;
    end

    @(posedge clk);
    #1;
    n_checks += 3;
    if (fifo_wr_en !== m_wr_en) begin
      n_fail++; $display("FAIL fifo_wr_en t=%0t got %b expected %b", $time, fifo_wr_en, m_wr_en);
    end
    if (fifo_din !== m_din) begin
      n_fail++; $display("FAIL fifo_din t=%0t got %h expected %h", $time, fifo_din, m_din);
    end
    if (wr_count !== m_cnt) begin
      n_fail++; $display("FAIL wr_count t=%0t got %h expected %h", $time, wr_count, m_cnt);
    end
    if (fifo_wr_en === 1'b1) writes.push_back(fifo_din);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    #1;
    n_checks += 6;
    if (gnt !== 4'b0)         begin n_fail++; $display("FAIL reset_gnt got %b expected 0", gnt); end
    if (fifo_wr_en !== 1'b0)  begin n_fail++; $display("FAIL reset_wr_en got %b expected 0", fifo_wr_en); end
    if (fifo_din !== '0)      begin n_fail++; $display("FAIL reset_din got %h expected 0", fifo_din); end
    if (wr_count !== 16'h0)   begin n_fail++; $display("FAIL reset_wr_count got %h expected 0", wr_count); end
    if (owner !== 2'd0)       begin n_fail++; $display("FAIL reset_owner got %0d expected 0", owner); end
    if (busy !== 1'b0)        begin n_fail++; $display("FAIL reset_busy got %b expected 0", busy); end
    do_reset();
  endtask

  task automatic test_single();
    logic [W-1:0] exp_d[3];
    exp_d[0] = 8'hA1; exp_d[1] = 8'hA2; exp_d[2] = 8'hA3;
    do_reset();
    cycle(4'b0001, {24'h0, 8'hA1}, 4'b0000, 1'b0);
    cycle(4'b0001, {24'h0, 8'hA1}, 4'b0000, 1'b0);
    cycle(4'b0001, {24'h0, 8'hA2}, 4'b0000, 1'b0);
    cycle(4'b0001, {24'h0, 8'hA3}, 4'b0001, 1'b0);
    cycle(4'b0000, '0, 4'b0000, 1'b0);
    n_checks += 2;
    if (writes.size() != 3) begin
      n_fail++; $display("FAIL single_nwrites got %0d expected 3", writes.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (writes[i] !== exp_d[i]) begin
          n_fail++; $display("FAIL single_data[%0d] got %h expected %h", i, writes[i], exp_d[i]);
        end
      end
    end
    if (wr_count !== 16'd3) begin
      n_fail++; $display("FAIL single_wr_count got %0d expected 3", wr_count);
    end
  endtask

  task automatic test_round_robin();
    int exp_o[5];
    exp_o = '{0, 1, 2, 3, 0};
    do_reset();
    repeat (25) cycle(4'b1111, rnd_data(), 4'b0000, 1'b0);
    n_checks++;
    if (owners.size() < 5) begin
      n_fail++; $display("FAIL rr_nbursts got %0d expected >=5", owners.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (owners[i] != exp_o[i]) begin
          n_fail++; $display("FAIL rr_owner[%0d] got %0d expected %0d", i, owners[i], exp_o[i]);
        end
      end
    end
    n_checks++;
    if (wr_count !== 16'd20) begin
      n_fail++; $display("FAIL rr_wr_count got %0d expected 20", wr_count);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] sent[$];
    logic [4*W-1:0] d;
    do_reset();
    cycle(4'b0100, rnd_data(), 4'b0000, 1'b0);
    for (int i = 0; i < 2; i++) begin
      d = rnd_data(); sent.push_back(d[2*W +: W]);
      cycle(4'b0100, d, 4'b0000, 1'b0);
    end
    repeat (3) cycle(4'b0100, rnd_data(), 4'b0000, 1'b1);
    for (int i = 0; i < 2; i++) begin
      d = rnd_data(); sent.push_back(d[2*W +: W]);
      cycle(4'b0100, d, 4'b0000, 1'b0);
    end
    cycle(4'b0000, '0, 4'b0000, 1'b0);
    n_checks += 2;
    if (writes.size() != 4) begin
      n_fail++; $display("FAIL bp_nwrites got %0d expected 4", writes.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (writes[i] !== sent[i]) begin
          n_fail++; $display("FAIL bp_data[%0d] got %h expected %h", i, writes[i], sent[i]);
        end
      end
    end
    if (wr_count !== 16'd4) begin
      n_fail++; $display("FAIL bp_wr_count got %0d expected 4", wr_count);
    end
  endtask

  task automatic test_withdraw();
    do_reset();
    repeat (3) cycle(4'b0010, rnd_data(), 4'b0000, 1'b0);
    cycle(4'b0000, rnd_data(), 4'b0000, 1'b0);
    cycle(4'b0101, rnd_data(), 4'b0000, 1'b0);
    n_checks += 2;
    if (owner !== 2'd2) begin
      n_fail++; $display("FAIL wd_next_owner got %0d expected 2", owner);
    end
    if (writes.size() != 2) begin
      n_fail++; $display("FAIL wd_nwrites got %0d expected 2", writes.size());
    end
    cycle(4'b0000, '0, 4'b0000, 1'b0);
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    cycle(4'b0001, rnd_data(), 4'b0000, 1'b0);
    cycle(4'b0001, rnd_data(), 4'b0000, 1'b0);
    req = 4'b0001; req_data = rnd_data();
    #2;
    n_checks++;
    if (gnt !== 4'b0001) begin
      n_fail++; $display("FAIL rm_gnt_before got %b expected 0001", gnt);
    end
    rst = 1'b1;
    #1;
    n_checks += 4;
    if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL rm_wr_en got %b expected 0", fifo_wr_en); end
    if (wr_count !== 16'h0)  begin n_fail++; $display("FAIL rm_wr_count got %h expected 0", wr_count); end
    if (gnt !== 4'b0)        begin n_fail++; $display("FAIL rm_gnt got %b expected 0", gnt); end
    if (busy !== 1'b0)       begin n_fail++; $display("FAIL rm_busy got %b expected 0", busy); end
    clear_inputs();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cycle(4'b1000, rnd_data(), 4'b0000, 1'b0);
    n_checks++;
    if (owner !== 2'd3) begin
      n_fail++; $display("FAIL rm_first_owner got %0d expected 3", owner);
    end
    cycle(4'b1000, rnd_data(), 4'b0000, 1'b0);
    cycle(4'b1000, rnd_data(), 4'b1000, 1'b0);
    cycle(4'b0000, '0, 4'b0000, 1'b0);
  endtask

  task automatic test_random();
    logic [3:0] r, l;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      r = 4'($urandom);
      if ($urandom_range(0, 9) < 7 && m_busy) r[m_owner] = 1'b1;
      l = '0;
      for (int b = 0; b < 4; b++) l[b] = ($urandom_range(0, 5) == 0);
      cycle(r, rnd_data(), l, $urandom_range(0, 3) == 0);
    end
  endtask

  task automatic test_max_burst_one();
    logic exp_g;
    do_reset();
    req1 = 4'b0001; last1 = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      data1 = rnd_data();
      #2;
      exp_g = (i % 2 == 1);
      n_checks += 2;
      if (gnt1 !== {3'b000, exp_g}) begin
        n_fail++; $display("FAIL mb1_gnt[%0d] got %b expected %b", i, gnt1, {3'b000, exp_g});
      end
      if (busy1 !== exp_g) begin
        n_fail++; $display("FAIL mb1_busy[%0d] got %b expected %b", i, busy1, exp_g);
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (cnt1 !== 16'd3) begin
      n_fail++; $display("FAIL mb1_wr_count got %0d expected 3", cnt1);
    end
    req1 = '0;
  endtask

  // 4095 full 16-beat bursts (17 clocks each) plus 1 arbitration clock and 14 beats = 65534 writes.
  task automatic test_wrap();
    logic [15:0] exp_c[3];
    exp_c[0] = 16'hFFFE; exp_c[1] = 16'hFFFF; exp_c[2] = 16'h0000;
    do_reset();
    req16 = 4'b0001; last16 = '0; full16 = 1'b0; data16 = rnd_data();
    repeat (4095 * 17 + 15) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (cnt16 !== exp_c[i]) begin
        n_fail++; $display("FAIL wrap_count[%0d] got %h expected %h", i, cnt16, exp_c[i]);
      end
      if (i < 2) begin
        @(posedge clk);
        #1;
      end
    end
    n_checks++;
    if (wen16 !== 1'b1) begin
      n_fail++; $display("FAIL wrap_wr_en got %b expected 1", wen16);
    end
    req16 = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_withdraw();
    test_reset_mid_burst();
    test_random();
    test_max_burst_one();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, the data width per requester and of the FIFO write port.
REQ-002 The block SHALL have parameter MAX_BURST, default 4, the maximum beats per grant; legal range 1..16.
REQ-003 Port clk, input, 1, clock; all logic on its rising edge.
REQ-004 Port rst, input, 1, reset: asynchronous, active-high.
REQ-005 Port req, input, 4, per-requester write request; bit i belongs to requester i.
REQ-006 Port req_data, input, 4*WIDTH, requester i data at bits [i*WIDTH +: WIDTH].
REQ-007 Port req_last, input, 4, per-requester end-of-burst marker, qualified by req[i].
REQ-008 Port gnt, output, 4, one-hot-or-zero beat acceptance; combinational.
REQ-009 Port fifo_full, input, 1, full flag from the downstream synchronous FIFO.
REQ-010 Port fifo_wr_en, output, 1, registered write enable to the FIFO.
REQ-011 Port fifo_din, output, WIDTH, registered write data to the FIFO.
REQ-012 Port owner, output, 2, index of the current or most recent grant holder.
REQ-013 Port busy, output, 1, high while in state BURST.
REQ-014 Port wr_count, output, 16, total beats written since reset; wraps 0xFFFF -> 0x0000.

Function
REQ-015 The FSM SHALL have two states: IDLE and BURST.
REQ-016 In IDLE with req != 0: winner = first set bit of req, searching round-robin from (last_owner+1) mod 4; owner <= winner; beat_cnt <= 0; next state BURST.
REQ-017 In IDLE: no beat transfers; gnt = 0; with req == 0, stay in IDLE.
REQ-018 In BURST: acc = req[owner] && !fifo_full; gnt[owner] = acc; all other gnt bits 0.
REQ-019 On acc: next cycle fifo_wr_en = 1 and fifo_din = req_data[owner] (1-cycle latency); beat_cnt += 1; wr_count += 1.
REQ-020 When acc is 0 in any cycle, the next cycle SHALL have fifo_wr_en = 0; fifo_din holds its previous value.
REQ-021 BURST exits to IDLE on acc && (req_last[owner] || beat_cnt == MAX_BURST-1); the final beat is written.
REQ-022 BURST exits to IDLE with no transfer when req[owner] == 0 (requester withdrew).
REQ-023 With req[owner] = 1 and fifo_full = 1: stay in BURST; no beat accepted; beat_cnt unchanged; no timeout.
REQ-024 On every BURST exit: last_owner <= owner. Minimum 1 IDLE cycle between bursts.
REQ-025 A single arbiter SHALL never accept more than one beat per cycle; gnt SHALL never have more than one bit set.
REQ-026 Requests from non-owners during BURST SHALL be ignored until the next IDLE arbitration.
REQ-027 beat_cnt is 4 bits wide; with MAX_BURST = 1, every accepted beat ends the burst.

Reset
REQ-028 On rst high, immediately and regardless of clk: state = IDLE; owner = 0; last_owner = 3 (requester 0 highest first priority); beat_cnt = 0; fifo_wr_en = 0; fifo_din = 0; wr_count = 0; busy = 0; gnt = 0.
REQ-029 Reset mid-burst SHALL abandon the burst; no further write is issued; after release, arbitration restarts from requester 0.

Verification
REQ-030 Single requester: req = 0001, data 0xA1,0xA2,0xA3 with last on the third beat, fifo_full = 0 -> IDLE 1 cycle, then gnt[0] for 3 cycles; fifo_wr_en for 3 cycles delayed by 1; fifo_din = A1,A2,A3; wr_count = 3; back to IDLE.
REQ-031 Round-robin: req = 1111 held, req_last = 0, MAX_BURST = 4 -> bursts of 4 beats in owner order 0,1,2,3,0, separated by 1 IDLE cycle.
REQ-032 Backpressure: owner 2 in BURST; fifo_full = 1 for 3 cycles mid-burst -> gnt = 0 and fifo_wr_en = 0 for those cycles; beat_cnt frozen; burst resumes; all 4 beats written, none lost or duplicated.
REQ-033 Withdrawal: owner 1 drops req after 2 beats -> IDLE next cycle; last_owner = 1; if req = 0101, next owner = 2.
REQ-034 Reset mid-burst: rst pulsed asynchronously between clk edges during beat 2 -> fifo_wr_en = 0 immediately; wr_count = 0; with req = 1000 after release, first grant goes to owner 3.
REQ-035 Wrap: preload wr_count to 0xFFFE via 2 beats after 65534 writes (or force) -> values 0xFFFF then 0x0000.
